mesh_out_arbiter: RTL and testbench

- Per-output-port scheduler for one mesh router node.
- Shares a single output link among NUM_IN input FIFOs (N, S, E, W, local) using round-robin arbitration. It pops the winning FIFO head into a one-entry output register and presents it to the downstream hop with the pndng/pop handshake used across the mesh.
- One instance per output port; the route decode upstream produces the per-input req bits.

---
 rtl/mesh_pkg.sv | 26 ++
 rtl/rr_pick.sv | 30 +++
 rtl/mesh_out_arbiter.sv | 92 +++++++++
 tb/tb_mesh_out_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh router: packet type, port indices, FSM states.
package mesh_pkg;

    localparam int PCKG_SZ = 40;
    localparam int NUM_PORTS = 5;

    typedef logic [PCKG_SZ-1:0] pkt_t;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    // Output register occupancy; the FULL encoding doubles as the pndng flag.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_e;

    // Width of an index into n items; never zero so single-item buses stay legal.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester after ptr_i, wrapping modulo N.
module rr_pick
    import mesh_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = idxWidth(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          any_o
);

    int idx;

    // Scan ptr+1, ptr+2, ... and keep the first set request found.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                winner_o = IW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesh_out_arbiter.sv
// Per-output-port scheduler: round-robin picks an input FIFO head into a
// one-entry output register presented downstream with the pndng/pop handshake.
module mesh_out_arbiter
    import mesh_pkg::*;
#(
    parameter int pckg_sz = 40,
    parameter int NUM_IN  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN-1:0]           req,
    input  logic [NUM_IN*pckg_sz-1:0]   data_in,
    output logic [NUM_IN-1:0]           pop,
    output logic [pckg_sz-1:0]          data_out,
    output logic                        pndng,
    input  logic                        popin,
    output logic [idxWidth(NUM_IN)-1:0] grant_id,
    output logic [CNT_W-1:0]            pkt_cnt
);

    localparam int IW = idxWidth(NUM_IN);

    outState_e          state_q, state_d;
    logic [pckg_sz-1:0] data_q, data_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic          free;
    logic          anyReq;
    logic [IW-1:0] winner;

    rr_pick #(
        .N  (NUM_IN),
        .IW (IW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (anyReq)
    );

    // Next-state: drain on popin, refill from the winner whenever the register frees up.
    always_comb begin
        free    = (state_q == EMPTY) || popin;
        pop     = '0;
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if ((state_q == FULL) && popin) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = EMPTY;
        end

        if (free && anyReq) begin
            state_d = FULL;
            data_d  = data_in[int'(winner)*pckg_sz +: pckg_sz];
            grant_d = winner;
            ptr_d   = winner;
            if (!reset) begin
                pop = NUM_IN'(1) << winner;
            end
        end
    end

    // Output register, round-robin pointer and delivery counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_IN - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pndng    = (state_q == FULL);
    assign data_out = data_q;
    assign grant_id = grant_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_mesh_out_arbiter.sv
// Self-checking bench for mesh_out_arbiter: vector table plus hand sequences,
// with a scoreboard of granted packets compared when they land in data_out.
module tb_mesh_out_arbiter;

    localparam int PW = 40;
    localparam int NI = 5;
    localparam int CW = 4;

    logic            clk;
    logic            reset;
    logic [NI-1:0]   req;
    logic [NI*PW-1:0] data_in;
    logic [NI-1:0]   pop;
    logic [PW-1:0]   data_out;
    logic            pndng;
    logic            popin;
    logic [2:0]      grant_id;
    logic [CW-1:0]   pkt_cnt;

    mesh_out_arbiter #(
        .pckg_sz (PW),
        .NUM_IN  (NI),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .pop      (pop),
        .data_out (data_out),
        .pndng    (pndng),
        .popin    (popin),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt)
    );

    typedef struct {
        logic [PW-1:0] data;
        logic [2:0]    gid;
    } sbEntry_t;

    typedef struct {
        logic          doRst;
        logic [NI-1:0] req;
        logic          popin;
        logic [NI-1:0] expPop;
        logic          expPndng;
        logic [2:0]    expGrant;
        logic [CW-1:0] expCnt;
    } vec_t;

    sbEntry_t sb[$];
    vec_t     vecs[10];

    int checks = 0;
    int errors = 0;

    int            mPtr;
    logic          mFull;
    logic [CW-1:0] mCnt;
    logic [PW-1:0] mDout;
    logic [2:0]    mGid;

    logic [NI-1:0] popSeen;
    logic [PW-1:0] savedOut;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int modelPick(input logic [NI-1:0] r, input int ptr);
        for (int k = 1; k <= NI; k++) begin
            if (r[(ptr + k) % NI]) return (ptr + k) % NI;
        end
        return -1;
    endfunction

    task automatic setRandomData();
        for (int i = 0; i < NI; i++) data_in[i*PW +: PW] = {8'($urandom), 32'($urandom)};
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        popin = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_pndng", pndng, 0);
        checkOutput("rst_data", data_out, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_cnt", pkt_cnt, 0);
        reset = 1'b0;
        mPtr  = NI - 1;
        mFull = 1'b0;
        mCnt  = '0;
        mDout = '0;
        mGid  = '0;
        sb.delete();
    endtask

    // One cycle: drive at posedge+1, check pop at negedge, check registers at posedge+1.
    task automatic applyStimulus(input logic [NI-1:0] r, input logic p, output logic [NI-1:0] popObs);
        logic     mFree;
        int       w;
        sbEntry_t e;
        logic [NI-1:0] expPop;
        req   = r;
        popin = p;
        #4;
        mFree  = !mFull || p;
        w      = modelPick(r, mPtr);
        expPop = (mFree && w >= 0) ? (NI'(1) << w) : '0;
        checkOutput("pop", pop, expPop);
        popObs = pop;
        if (mFree && w >= 0) sb.push_back('{data_in[w*PW +: PW], 3'(w)});
        @(posedge clk);
        #1;
        if (mFull && p) mCnt = mCnt + 1'b1;
        if (mFree && w >= 0) begin
            mFull = 1'b1;
            mPtr  = w;
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 1, 0);
            end else begin
                e     = sb.pop_front();
                mDout = e.data;
                mGid  = e.gid;
            end
        end else if (mFree) begin
            mFull = 1'b0;
        end
        checkOutput("data_out", data_out, mDout);
        checkOutput("grant_id", grant_id, mGid);
        checkOutput("pndng", pndng, mFull);
        checkOutput("pkt_cnt", pkt_cnt, mCnt);
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        popin   = 1'b0;
        data_in = '0;

        // Rows 0-2: single request from input 2; rows 3-9: all inputs, popin every cycle.
        vecs[0] = '{1'b1, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2, 4'd0};
        vecs[1] = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b1, 3'd2, 4'd0};
        vecs[2] = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b1, 3'd2, 4'd0};
        vecs[3] = '{1'b1, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 4'd0};
        vecs[4] = '{1'b0, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1, 4'd1};
        vecs[5] = '{1'b0, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2, 4'd2};
        vecs[6] = '{1'b0, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3, 4'd3};
        vecs[7] = '{1'b0, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4, 4'd4};
        vecs[8] = '{1'b0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 4'd5};
        vecs[9] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 4'd6};

        setRandomData();
        data_in[2*PW +: PW] = 40'hA5;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].doRst) doReset();
            applyStimulus(vecs[i].req, vecs[i].popin, popSeen);
            checkOutput($sformatf("vec%0d_pop", i), popSeen, vecs[i].expPop);
            checkOutput($sformatf("vec%0d_pndng", i), pndng, vecs[i].expPndng);
            checkOutput($sformatf("vec%0d_grant", i), grant_id, vecs[i].expGrant);
            checkOutput($sformatf("vec%0d_cnt", i), pkt_cnt, vecs[i].expCnt);
            if (i == 0) checkOutput("t1_data", data_out, 40'hA5);
        end

        // Blocked output: hold with grant 3 while input 0 waits, then release.
        doReset();
        setRandomData();
        applyStimulus(5'b01000, 1'b0, popSeen);
        checkOutput("t3_grant", grant_id, 3);
        savedOut = data_out;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'b00001, 1'b0, popSeen);
            checkOutput("t3_hold_pop", popSeen, 0);
            checkOutput("t3_hold_data", data_out, savedOut);
        end
        applyStimulus(5'b00001, 1'b1, popSeen);
        checkOutput("t3_release_pop", popSeen, 5'b00001);
        checkOutput("t3_release_data", data_out, data_in[0 +: PW]);

        // popin while empty must not count.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 1'b1, popSeen);
        checkOutput("t4_cnt", pkt_cnt, 0);
        checkOutput("t4_pndng", pndng, 0);

        // Asynchronous reset while holding a packet, then priority restart at input 0.
        doReset();
        applyStimulus(5'b00100, 1'b0, popSeen);
        req = 5'b00010;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_async_pndng", pndng, 0);
        checkOutput("t5_async_data", data_out, 0);
        checkOutput("t5_async_pop", pop, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mPtr  = NI - 1;
        mFull = 1'b0;
        mCnt  = '0;
        mDout = '0;
        mGid  = '0;
        sb.delete();
        applyStimulus(5'b10001, 1'b0, popSeen);
        checkOutput("t5_first_pop", popSeen, 5'b00001);
        checkOutput("t5_first_grant", grant_id, 0);

        // Counter wrap: 17 deliveries on a 4-bit counter.
        doReset();
        for (int i = 0; i < 18; i++) begin
            setRandomData();
            applyStimulus(5'b11111, 1'b1, popSeen);
        end
        checkOutput("t6_wrap", pkt_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
